// File: rtl/sys_prof_pkg.sv
// Shared types and helpers for the systolic activity profiler.
// Optional peak tracking is enabled by defining PROF_PEAK_EN.
package sys_prof_pkg;

  typedef enum logic [1:0] {
    PROF_IDLE = 2'd0,
    PROF_RUN  = 2'd1,
    PROF_DUMP = 2'd2
  } prof_state_e;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ROWS  = 8;
  localparam int DEF_COLS  = 8;
  localparam int DEF_NPE   = DEF_ROWS * DEF_COLS;
  localparam int DEF_IDX_W = idx_w(DEF_NPE);
  localparam int DEF_ROW_W = idx_w(DEF_ROWS);
  localparam int DEF_COL_W = idx_w(DEF_COLS);
  localparam int DEF_POP_W = $clog2(DEF_NPE + 1);

  // a + b clamped to the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    sum     = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val})
      return max_val;
    return sum[63:0];
  endfunction

endpackage

// File: rtl/sys_prof_popcount.sv
// Combinational population count of a flag vector.
module sys_prof_popcount #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]           bits,
  output logic [$clog2(WIDTH+1)-1:0] count
);

  localparam int CW = $clog2(WIDTH + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++)
      count = count + CW'(bits[i]);
  end

endmodule

// File: rtl/systolic_activity_profiler.sv
// Per-PE activity profiler: saturating counters sampled on gated cycles, read out row-major.
// Define PROF_PEAK_EN to add peak_active / peak_cycle tracking.
module systolic_activity_profiler
  import sys_prof_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic                                     stop,
  input  logic [WIN_W-1:0]                         window_len,
  input  logic                                     compute_phase,
  input  logic [ROWS*COLS-1:0]                     pe_active,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     rd_valid,
  input  logic                                     rd_ready,
  output logic [$clog2(ROWS)-1:0]                  rd_row,
  output logic [$clog2(COLS)-1:0]                  rd_col,
  output logic [CNT_W-1:0]                         rd_count,
  output logic                                     rd_last,
  output logic [CNT_W-1:0]                         total_cycles,
  output logic [CNT_W+$clog2(ROWS*COLS+1)-1:0]     active_sum
`ifdef PROF_PEAK_EN
  ,
  output logic [$clog2(ROWS*COLS+1)-1:0]           peak_active,
  output logic [CNT_W-1:0]                         peak_cycle
`endif
);

  localparam int NPE   = ROWS * COLS;
  localparam int IDX_W = idx_w(NPE);
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int POP_W = $clog2(NPE + 1);
  localparam int SUM_W = CNT_W + POP_W;

  prof_state_e        state_reg;
  logic [WIN_W-1:0]   window_reg;
  logic [CNT_W-1:0]   total_reg;
  logic [CNT_W-1:0]   total_next;
  logic [SUM_W-1:0]   sum_reg;
  logic [SUM_W-1:0]   sum_next;
  logic [POP_W-1:0]   pop_count;
  logic [CNT_W-1:0]   cnt_reg  [NPE];
  logic [CNT_W-1:0]   cnt_next [NPE];

  logic [IDX_W-1:0]   idx_reg;
  logic [IDX_W-1:0]   idx_next;
  logic [ROW_W-1:0]   row_reg;
  logic [COL_W-1:0]   col_reg;
  logic [CNT_W-1:0]   rd_count_reg;
  logic               rd_valid_reg;
  logic               rd_last_reg;
  logic               done_reg;

  logic sample;
  logic start_clear;
  logic win_hit;
  logic run_exit;
  logic rd_fire;

  sys_prof_popcount #(.WIDTH(NPE)) u_popcount (
    .bits  (pe_active),
    .count (pop_count)
  );

  assign sample      = (state_reg == PROF_RUN) && compute_phase;
  assign start_clear = (state_reg == PROF_IDLE) && start;
  assign total_next  = CNT_W'(sat_add(64'(total_reg), 64'd1, CNT_W));
  assign sum_next    = SUM_W'(sat_add(64'(sum_reg), 64'(pop_count), SUM_W));
  // A saturated total can never reach a window wider than the counter, so such runs end only on stop.
  assign win_hit     = sample && (window_reg != '0) && (64'(total_next) == 64'(window_reg));
  assign run_exit    = (state_reg == PROF_RUN) && (stop || win_hit);
  assign rd_fire     = rd_valid_reg && rd_ready;
  assign idx_next    = idx_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NPE; gi++) begin : g_pe_cnt
      assign cnt_next[gi] = sample
        ? CNT_W'(sat_add(64'(cnt_reg[gi]), 64'(pe_active[gi]), CNT_W))
        : cnt_reg[gi];

      always_ff @(posedge clk) begin
        if (rst)
          cnt_reg[gi] <= '0;
        else if (start_clear)
          cnt_reg[gi] <= '0;
        else
          cnt_reg[gi] <= cnt_next[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= PROF_IDLE;
      window_reg   <= '0;
      total_reg    <= '0;
      sum_reg      <= '0;
      idx_reg      <= '0;
      row_reg      <= '0;
      col_reg      <= '0;
      rd_count_reg <= '0;
      rd_valid_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        PROF_IDLE: begin
          if (start) begin
            state_reg  <= PROF_RUN;
            window_reg <= window_len;
            total_reg  <= '0;
            sum_reg    <= '0;
          end
        end
        PROF_RUN: begin
          if (sample) begin
            total_reg <= total_next;
            sum_reg   <= sum_next;
          end
          if (run_exit) begin
            // Entry 0 must include the sample taken on this very edge.
            state_reg    <= PROF_DUMP;
            idx_reg      <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            rd_count_reg <= cnt_next[0];
            rd_valid_reg <= 1'b1;
            rd_last_reg  <= (NPE == 1);
          end
        end
        PROF_DUMP: begin
          if (rd_fire) begin
            if (rd_last_reg) begin
              state_reg    <= PROF_IDLE;
              rd_valid_reg <= 1'b0;
              rd_last_reg  <= 1'b0;
              done_reg     <= 1'b1;
            end else begin
              idx_reg      <= idx_next;
              rd_count_reg <= cnt_reg[idx_next];
              rd_last_reg  <= (idx_next == IDX_W'(NPE - 1));
              if (col_reg == COL_W'(COLS - 1)) begin
                col_reg <= '0;
                row_reg <= row_reg + 1'b1;
              end else begin
                col_reg <= col_reg + 1'b1;
              end
            end
          end
        end
        default: state_reg <= PROF_IDLE;
      endcase
    end
  end

`ifdef PROF_PEAK_EN
  logic [POP_W-1:0] peak_active_reg;
  logic [CNT_W-1:0] peak_cycle_reg;

  // Strictly greater keeps the earliest cycle on ties.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_active_reg <= '0;
      peak_cycle_reg  <= '0;
    end else if (start_clear) begin
      peak_active_reg <= '0;
      peak_cycle_reg  <= '0;
    end else if (sample && (pop_count > peak_active_reg)) begin
      peak_active_reg <= pop_count;
      peak_cycle_reg  <= total_next;
    end
  end

  assign peak_active = peak_active_reg;
  assign peak_cycle  = peak_cycle_reg;
`endif

  assign busy         = (state_reg != PROF_IDLE);
  assign done         = done_reg;
  assign rd_valid     = rd_valid_reg;
  assign rd_row       = row_reg;
  assign rd_col       = col_reg;
  assign rd_count     = rd_count_reg;
  assign rd_last      = rd_last_reg;
  assign total_cycles = total_reg;
  assign active_sum   = sum_reg;

endmodule

// File: tb/tb_systolic_activity_profiler.sv
// Self-checking bench for systolic_activity_profiler (2x2, 4-bit counters).
// Define PROF_PEAK_EN to also exercise the peak outputs.
module tb_systolic_activity_profiler;

  localparam int ROWS  = 2;
  localparam int COLS  = 2;
  localparam int CNT_W = 4;
  localparam int WIN_W = 8;
  localparam int NPE   = ROWS * COLS;
  localparam int POP_W = $clog2(NPE + 1);
  localparam int SUM_W = CNT_W + POP_W;
  localparam int RW    = $clog2(ROWS);
  localparam int CLW   = $clog2(COLS);
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int SMAX  = (1 << SUM_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [WIN_W-1:0] window_len = '0;
  logic             compute_phase = 1'b0;
  logic [NPE-1:0]   pe_active = '0;
  logic             busy, done, rd_valid, rd_last;
  logic             rd_ready = 1'b0;
  logic [RW-1:0]    rd_row;
  logic [CLW-1:0]   rd_col;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] total_cycles;
  logic [SUM_W-1:0] active_sum;
`ifdef PROF_PEAK_EN
  logic [POP_W-1:0] peak_active;
  logic [CNT_W-1:0] peak_cycle;
`endif

  systolic_activity_profiler #(
    .ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W), .WIN_W(WIN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .window_len(window_len),
    .compute_phase(compute_phase), .pe_active(pe_active), .busy(busy), .done(done),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_row(rd_row), .rd_col(rd_col),
    .rd_count(rd_count), .rd_last(rd_last), .total_cycles(total_cycles),
    .active_sum(active_sum)
`ifdef PROF_PEAK_EN
    , .peak_active(peak_active), .peak_cycle(peak_cycle)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 run, 2 dump; counts kept as plain ints.
  int m_phase = 0, m_total = 0, m_sum = 0, m_win = 0, m_idx = 0;
  int m_peak = 0, m_peak_cyc = 0;
  int m_cnt [NPE];
  bit m_done = 0, m_ok = 0;

  function automatic int sat(input int v, input int max_v);
    return (v > max_v) ? max_v : v;
  endfunction

  always @(posedge clk) begin
    int pop;
    pop = $countones(pe_active);
    if (rst) begin
      m_phase = 0; m_total = 0; m_sum = 0; m_win = 0; m_idx = 0;
      m_peak = 0; m_peak_cyc = 0; m_done = 0; m_ok = 1;
      for (int i = 0; i < NPE; i++) m_cnt[i] = 0;
    end else begin
      m_done = 0;
      if (m_phase == 0) begin
        if (start) begin
          m_phase = 1; m_total = 0; m_sum = 0; m_peak = 0; m_peak_cyc = 0;
          m_win = int'(window_len);
          for (int i = 0; i < NPE; i++) m_cnt[i] = 0;
        end
      end else if (m_phase == 1) begin
        if (compute_phase) begin
          m_total = sat(m_total + 1, CMAX);
          m_sum   = sat(m_sum + pop, SMAX);
          for (int i = 0; i < NPE; i++) m_cnt[i] = sat(m_cnt[i] + int'(pe_active[i]), CMAX);
          if (pop > m_peak) begin m_peak = pop; m_peak_cyc = m_total; end
        end
        if (stop || (compute_phase && m_win != 0 && m_total == m_win)) begin
          m_phase = 2; m_idx = 0;
        end
      end else begin
        if (rd_ready) begin
          if (m_idx == NPE - 1) begin m_phase = 0; m_done = 1; end
          else m_idx++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("busy", 64'(busy), 64'(m_phase != 0));
      check("done", 64'(done), 64'(m_done));
      check("rd_valid", 64'(rd_valid), 64'(m_phase == 2));
      check("rd_last", 64'(rd_last), 64'(m_phase == 2 && m_idx == NPE - 1));
      check("total_cycles", 64'(total_cycles), 64'(m_total));
      check("active_sum", 64'(active_sum), 64'(m_sum));
      if (m_phase == 2) begin
        check("rd_row", 64'(rd_row), 64'(m_idx / COLS));
        check("rd_col", 64'(rd_col), 64'(m_idx % COLS));
        check("rd_count", 64'(rd_count), 64'(m_cnt[m_idx]));
      end
`ifdef PROF_PEAK_EN
      check("peak_active", 64'(peak_active), 64'(m_peak));
      check("peak_cycle", 64'(peak_cycle), 64'(m_peak_cyc));
`endif
    end
  end

  int rec_n, n_done;
  int rec_cnt [NPE];
  int rec_last [NPE];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int win);
    start = 1'b1;
    window_len = WIN_W'(win);
    step();
    start = 1'b0;
  endtask

  // Drains the readout, recording each accepted entry and its order.
  task automatic drain(input int stall, input bit rnd);
    rec_n = 0;
    n_done = 0;
    for (int k = 0; k < 200; k++) begin
      rd_ready = (k < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (rd_valid && rd_ready) begin
        if (rec_n < NPE) begin
          rec_cnt[rec_n]  = int'(rd_count);
          rec_last[rec_n] = int'(rd_last);
          check("order_row", 64'(rd_row), 64'(rec_n / COLS));
          check("order_col", 64'(rd_col), 64'(rec_n % COLS));
        end
        rec_n++;
      end
      step();
      if (done) n_done++;
      if (!busy) break;
    end
    rd_ready = 1'b0;
    check("drain_finished", 64'(busy), 64'(0));
    step();
    if (done) n_done++;
    check("entries_read", 64'(rec_n), 64'(NPE));
    check("done_pulses", 64'(n_done), 64'(1));
  endtask

  initial begin
    repeat (2) step();
    rst = 1'b0;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_total", 64'(total_cycles), 64'(0));
    check("reset_valid", 64'(rd_valid), 64'(0));

    // Basic bounded window
    start_run(4);
    compute_phase = 1'b1;
    pe_active = 4'b0101;
    repeat (4) step();
    compute_phase = 1'b0;
    pe_active = '0;
    drain(0, 1'b0);
    check("win_e0", 64'(rec_cnt[0]), 64'(4));
    check("win_e1", 64'(rec_cnt[1]), 64'(0));
    check("win_e2", 64'(rec_cnt[2]), 64'(4));
    check("win_e3", 64'(rec_cnt[3]), 64'(0));
    check("win_last0", 64'(rec_last[0]), 64'(0));
    check("win_last3", 64'(rec_last[3]), 64'(1));
    check("win_total", 64'(total_cycles), 64'(4));
    check("win_sum", 64'(active_sum), 64'(8));

    // Gating with stop on a gated cycle
    start_run(0);
    for (int k = 0; k < 5; k++) begin
      compute_phase = (k % 2 == 0);
      pe_active = 4'hF;
      stop = (k == 4);
      step();
    end
    stop = 1'b0; compute_phase = 1'b0; pe_active = '0;
    drain(0, 1'b0);
    for (int i = 0; i < NPE; i++) check("gate_cnt", 64'(rec_cnt[i]), 64'(3));
    check("gate_total", 64'(total_cycles), 64'(3));
    check("gate_sum", 64'(active_sum), 64'(12));

    // Backpressure
    start_run(0);
    for (int k = 0; k < 8; k++) begin
      compute_phase = 1'($urandom_range(0, 1));
      pe_active = NPE'($urandom);
      stop = (k == 7);
      step();
    end
    stop = 1'b0; compute_phase = 1'b0;
    drain(5, 1'b1);

    // Saturation
    start_run(0);
    compute_phase = 1'b1;
    pe_active = 4'hF;
    for (int k = 0; k < 20; k++) begin
      stop = (k == 19);
      step();
    end
    stop = 1'b0; compute_phase = 1'b0;
    drain(0, 1'b0);
    for (int i = 0; i < NPE; i++) check("sat_cnt", 64'(rec_cnt[i]), 64'(15));
    check("sat_total", 64'(total_cycles), 64'(15));
    check("sat_sum", 64'(active_sum), 64'(80));

    // Reset mid-run and mid-dump
    start_run(0);
    compute_phase = 1'b1;
    pe_active = NPE'($urandom);
    repeat (3) step();
    rst = 1'b1; step(); rst = 1'b0;
    check("rstrun_busy", 64'(busy), 64'(0));
    check("rstrun_total", 64'(total_cycles), 64'(0));
    check("rstrun_sum", 64'(active_sum), 64'(0));
    start_run(0);
    stop = 1'b1; step(); stop = 1'b0;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    check("rstdump_valid", 64'(rd_valid), 64'(0));
    check("rstdump_done", 64'(done), 64'(0));
    start_run(3);
    pe_active = 4'b1100;
    repeat (3) step();
    compute_phase = 1'b0;
    drain(0, 1'b1);
    check("fresh_total", 64'(total_cycles), 64'(3));
    check("fresh_e3", 64'(rec_cnt[3]), 64'(3));

`ifdef PROF_PEAK_EN
    start_run(4);
    compute_phase = 1'b1;
    pe_active = 4'b0001; step();
    pe_active = 4'b0111; step();
    pe_active = 4'b1011; step();
    pe_active = 4'b0011; step();
    compute_phase = 1'b0;
    drain(0, 1'b0);
    check("peak_active_lit", 64'(peak_active), 64'(3));
    check("peak_cycle_lit", 64'(peak_cycle), 64'(2));
`endif

    // Random soak, including stray start/stop and occasional reset
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 7) == 0);
      stop = ($urandom_range(0, 9) == 0);
      compute_phase = ($urandom_range(0, 3) != 0);
      pe_active = NPE'($urandom);
      window_len = WIN_W'($urandom_range(0, 20));
      rd_ready = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/systolic_activity_profiler.md
Name: systolic_activity_profiler

Overview:
- Synthesizable per-PE activity profiler for the systolic arrays (IS/WS), generalised to ROWS x COLS.
- Samples one activity flag per PE per cycle (operand-nonzero, computed by the array wrapper) during gated compute cycles, over a bounded or open window.
- Accumulates saturating per-PE counts, then streams them out row-major over a valid/ready port.
- Replaces text-log profiling with on-chip counters usable in simulation and in hardware.

Parameters:
- ROWS, 8, PE rows in the monitored array
- COLS, 8, PE columns in the monitored array
- CNT_W, 16, width of per-PE counters and the cycle counter
- WIN_W, 16, width of window_len

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; arms a new profiling run (honoured only in IDLE)
- stop  in  1  ends RUN early (honoured only in RUN)
- window_len  in  WIN_W  gated-cycle budget, latched at start; 0 = unbounded (until stop)
- compute_phase  in  1  sample gate; counting occurs only when high
- pe_active  in  ROWS*COLS  activity flags, bit r*COLS+c = PE(r,c)
- busy  out  1  high in RUN or DUMP
- done  out  1  one-cycle pulse after the final readout handshake
- rd_valid  out  1  readout data valid
- rd_ready  in  1  consumer ready
- rd_row  out  $clog2(ROWS)  row of current entry
- rd_col  out  $clog2(COLS)  column of current entry
- rd_count  out  CNT_W  active-cycle count of current entry
- rd_last  out  1  high with the final entry (index ROWS*COLS-1)
- total_cycles  out  CNT_W  gated cycles counted in the last/current run (saturating)
- active_sum  out  CNT_W+$clog2(ROWS*COLS+1)  total PE-active cycles (saturating)

Behaviour:
- Reset: every output and register is 0, state IDLE. Reset asserted mid-RUN or mid-DUMP aborts the run immediately; no done pulse.
- States: IDLE, RUN, DUMP.
- IDLE:
  - start=1 -> RUN next cycle.
  - On the same edge: clear all PE counters, total_cycles and active_sum; latch window_len.
  - The start cycle itself is not sampled.
- RUN:
  - Each cycle with compute_phase=1: total_cycles += 1; each PE counter += its pe_active bit; active_sum += popcount(pe_active).
  - All counters saturate at all-ones and never wrap.
- Exit RUN -> DUMP when either:
  - stop=1. The sample on the stop cycle is still taken if compute_phase=1.
  - window_len != 0 and this cycle's gated sample makes total_cycles equal to the latched window_len. Exactly window_len samples are taken.
- Simultaneous stop and window expiry: single transition to DUMP; sample taken once.
- start outside IDLE is ignored. stop outside RUN is ignored.
- DUMP:
  - Index idx starts at 0; rd_valid=1 from the first DUMP cycle.
  - rd_row = idx / COLS, rd_col = idx % COLS, rd_count = counter[idx]; all registered (no combinational path from rd_ready).
  - idx advances only on rd_valid && rd_ready. Outputs hold stable while rd_ready=0.
  - Handshake at idx = ROWS*COLS-1 (rd_last=1): rd_valid drops next cycle, done pulses for one cycle, state -> IDLE.
  - A start on the done cycle is accepted.
- total_cycles and active_sum hold their final values in IDLE until the next start clears them.
- busy = (state != IDLE).

Optional Feature:
- Macro: PROF_PEAK_EN.
- When defined:
  - Extra output peak_active, width $clog2(ROWS*COLS+1): the maximum popcount(pe_active) over gated RUN cycles.
  - Extra output peak_cycle, width CNT_W: the total_cycles value at the first cycle that reached that maximum (strict-greater update, so ties keep the earliest).
  - Both are cleared on start and are 0 at reset.
- When undefined: both ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package sys_prof_pkg holds:
  - the state enum (PROF_IDLE, PROF_RUN, PROF_DUMP);
  - the function sat_add(a, b, width);
  - localparams for NPE = ROWS*COLS and the index widths.
- Sub-module sys_prof_popcount (parameter WIDTH): combinational popcount of pe_active, shared by the active_sum and peak logic.
- Per-PE counters are a generate array inside the top module.

Test Plan:
- Basic window (2x2 override): start, window_len=4, compute_phase=1, pe_active=4'b0101 for 4 cycles -> DUMP entries (0,0)=4, (0,1)=0, (1,0)=4, (1,1)=0; total_cycles=4; active_sum=8; rd_last on entry 3; done pulses once.
- Gating and stop: window_len=0, compute_phase toggling 1,0,1,0,1 with pe_active all-ones, stop on cycle 5 (gated) -> every count=3; total_cycles=3.
- Backpressure: during DUMP hold rd_ready=0 for 5 cycles, then random -> each entry appears exactly once, in row-major order, stable while stalled.
- Saturation (CNT_W=4): 20 gated cycles with all PEs active -> counts=15; total_cycles=15; no wrap.
- Reset mid-run: assert rst during RUN and again during DUMP -> all outputs 0, IDLE, no done; a fresh start then profiles correctly.
- PROF_PEAK_EN (8x8): popcounts 3, 7, 7, 2 on gated cycles 1-4 -> peak_active=7, peak_cycle=2.
